keypad_matrix_emulator: RTL and testbench
=========================================

Name: keypad_matrix_emulator

Overview:
- Synthesizable 4x4 matrix-keypad emulator. It is the responder on the other end of the keypad scan interface: it watches the scanner's row_sweep and drives the column lines the way a physical keypad with one pressed key would.
- Used on the board in place of the real keypad and in benches, so the scanner, calculator FSM and display can be exercised by scripted key presses.
- Each press is commanded by a valid/ready request and includes emulated contact bounce on make and on break.

Parameters:
- ACTIVE_LOW, 1: row_sweep and column_in polarity. 1 means the asserted line is 0 and idle lines are 1.
- BOUNCE_CYCLES, 32: length in clk cycles of each bounce window, at make and at break. 0 disables bounce.
- GAP_CYCLES, 16: minimum released time in clk cycles after a press before the next request is accepted.
- HOLD_W, 16: width of the req_hold field.
- LFSR_SEED, 16'hACE1: reset value of the 16-bit bounce LFSR. Must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- row_sweep  in  4  row drive from the scanner. One row asserted at a time, per ACTIVE_LOW.
- column_in  out  4  column lines back to the scanner, per ACTIVE_LOW
- req_valid  in  1  press request valid
- req_ready  out  1  emulator can accept a request
- req_key  in  4  key position. Row = req_key[3:2], column = req_key[1:0].
- req_hold  in  HOLD_W  stable-press duration in clk cycles
- contact  out  1  current emulated switch contact state (1 = closed)
- busy  out  1  a press sequence is in progress
- done  out  1  one-cycle pulse when a sequence completes

Behaviour:
- State register holds IDLE, MAKE, HOLD, BREAK, GAP. It also holds key_r[3:0], a cycle counter cnt sized for max(HOLD_W, clog2 of BOUNCE_CYCLES and GAP_CYCLES) and the 16-bit LFSR.
- Reset (asynchronous, rst=1): state=IDLE, key_r=0, cnt=0, LFSR=LFSR_SEED, contact=0, busy=0, done=0, req_ready=1. column_in is all columns deasserted (4'hF when ACTIVE_LOW=1). Reset mid-press aborts the press immediately; no done pulse is produced.
- Handshake:
  - req_ready = (state==IDLE).
  - A request is accepted on a rising edge with req_valid & req_ready. At acceptance, key_r<=req_key and hold_r<=max(req_hold,1). So req_hold=0 behaves as 1.
  - req_valid while busy is ignored; it is not queued.
- IDLE: on acceptance go to MAKE, or directly to HOLD when BOUNCE_CYCLES=0. cnt<=0.
- MAKE: lasts BOUNCE_CYCLES cycles. contact = LFSR[0]. The LFSR is Fibonacci with taps 16,14,13,11 and advances every cycle in MAKE and BREAK only. Go to HOLD after the last MAKE cycle.
- HOLD: contact=1 for exactly hold_r cycles, then BREAK, or GAP when BOUNCE_CYCLES=0.
- BREAK: same as MAKE, with contact = LFSR[0], for BOUNCE_CYCLES cycles, then GAP.
- GAP: contact=0 for GAP_CYCLES cycles (minimum 1). Then go to IDLE and assert done for that single transition cycle.
- busy = (state != IDLE). contact, busy and done are registered.
- column_in is combinational from row_sweep, with zero latency, like a passive switch:
  - The column key_r[1:0] is asserted iff contact=1 and row_sweep bit key_r[3:2] is asserted.
  - All other columns are always deasserted.
  - If several rows are asserted, the same rule applies (only the key's own row matters).
  - Rows change while contact=1: column_in tracks them in the same cycle.
- Counters saturate at their terminal count; there is no wrap during a phase. cnt is cleared on every state change.
- Total press time from acceptance to done = 2*BOUNCE_CYCLES + hold_r + GAP_CYCLES cycles.

Test Plan:
1. Reset behaviour: ACTIVE_LOW=1, rst pulsed mid-HOLD with key 4'h5 -> column_in=4'hF and contact=0 asynchronously; req_ready=1 on the next edge; no done pulse.
2. Basic press: BOUNCE_CYCLES=0, GAP=16, req_key=4'h9, req_hold=100.
   - contact=1 for exactly 100 cycles.
   - While row_sweep=4'b1011: column_in=4'b1101.
   - While row_sweep=4'b1110: column_in=4'hF.
   - done pulses 116 cycles after acceptance.
3. Bounce: BOUNCE_CYCLES=32, seed 16'hACE1 -> contact during MAKE matches the reference LFSR[0] sequence, and is then held at 1 for hold_r cycles.
4. Handshake: req_valid held high through a press with a different req_key -> second key accepted only on the cycle after done; first key_r is unaffected.
5. Hold zero: req_hold=0, BOUNCE_CYCLES=0 -> contact=1 for exactly 1 cycle.
6. End-to-end: key_code 4'h0 then 4'hF with hold long enough for the scanner's debounce -> the scanner's pressed output fires twice with the matching enc_out codes.

Source files
------------

// File: rtl/keypad_matrix_emulator.sv
// 4x4 matrix-keypad emulator: plays one scripted key press per request, with
// LFSR-driven contact bounce on make and break, and answers row_sweep like a passive switch.
module keypad_matrix_emulator #(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int          BOUNCE_CYCLES = 32,
  parameter int          GAP_CYCLES    = 16,
  parameter int          HOLD_W        = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        row_sweep,
  output logic [3:0]        column_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_key,
  input  logic [HOLD_W-1:0] req_hold,
  output logic              contact,
  output logic              busy,
  output logic              done
);

  localparam int GAP_LEN = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int BNC_W   = $clog2(BOUNCE_CYCLES + 1);
  localparam int GAP_W   = $clog2(GAP_LEN + 1);
  localparam int PH_W    = (BNC_W > GAP_W) ? BNC_W : GAP_W;
  localparam int CNT_W   = (HOLD_W > PH_W) ? HOLD_W : PH_W;

  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAKE,
    S_HOLD,
    S_BREAK,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [3:0]         r_key;
  logic [HOLD_W-1:0]  r_hold;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_lfsr;
  logic               r_contact;
  logic               r_busy;
  logic               r_done;

  logic [15:0]        w_lfsr_next;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   w_hold_last;
  logic [3:0]         w_rows_asserted;
  logic [3:0]         w_cols_asserted;

  // Fibonacci LFSR, taps 16,14,13,11 of a right-shifting register.
  assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_hold_last = CNT_W'(r_hold) - 1'b1;

  assign req_ready = (r_state == S_IDLE);
  assign contact   = r_contact;
  assign busy      = r_busy;
  assign done      = r_done;

  // NOTE: every register here is updated with <= so all next-state terms read
  // the pre-edge values; blocking assignments would make results order-dependent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_key     <= '0;
      r_hold    <= '0;
      r_cnt     <= '0;
      r_lfsr    <= LFSR_SEED;
      r_contact <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_key  <= req_key;
            r_hold <= (req_hold == '0) ? HOLD_W'(1) : req_hold;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (BOUNCE_CYCLES == 0) begin
              r_state   <= S_HOLD;
              r_contact <= 1'b1;
            end else begin
              r_state   <= S_MAKE;
              r_contact <= r_lfsr[0];
            end
          end
        end
        S_MAKE: begin
          r_lfsr <= w_lfsr_next;
          if (r_cnt == BOUNCE_LAST) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_contact <= 1'b1;
          end else begin
            r_cnt     <= w_cnt_inc;
            r_contact <= w_lfsr_next[0];
          end
        end
        S_HOLD: begin
          if (r_cnt == w_hold_last) begin
            r_cnt <= '0;
            if (BOUNCE_CYCLES == 0) begin
              r_state   <= S_GAP;
              r_contact <= 1'b0;
            end else begin
              r_state   <= S_BREAK;
              r_contact <= r_lfsr[0];
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_BREAK: begin
          r_lfsr <= w_lfsr_next;
          if (r_cnt == BOUNCE_LAST) begin
            r_state   <= S_GAP;
            r_cnt     <= '0;
            r_contact <= 1'b0;
          end else begin
            r_cnt     <= w_cnt_inc;
            r_contact <= w_lfsr_next[0];
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_contact <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Passive switch path: only the pressed key's own row can close its column.
  // NOTE: w_cols_asserted gets a default before the conditional write, so no latch is inferred.
  always_comb begin
    w_rows_asserted = ACTIVE_LOW ? ~row_sweep : row_sweep;
    w_cols_asserted = 4'b0000;
    if (r_contact && w_rows_asserted[r_key[3:2]]) begin
      w_cols_asserted[r_key[1:0]] = 1'b1;
    end
    column_in = ACTIVE_LOW ? ~w_cols_asserted : w_cols_asserted;
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Scoreboard bench for keypad_matrix_emulator: one instance without bounce, one with
// 32-cycle bounce, both checked cycle by cycle against a phase-list reference model.
`timescale 1ns/1ps
module tb_keypad_matrix_emulator;

  localparam int          B1   = 32;
  localparam int          GAP  = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_sweep;
  logic        req_valid0, req_valid1;
  logic [3:0]  req_key0, req_key1;
  logic [15:0] req_hold0, req_hold1;
  logic [3:0]  column_in0, column_in1;
  logic        req_ready0, req_ready1;
  logic        contact0, contact1, busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  keypad_matrix_emulator #(.BOUNCE_CYCLES(0), .GAP_CYCLES(GAP)) dut0 (
    .clk(clk), .rst(rst), .row_sweep(row_sweep), .column_in(column_in0),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_key(req_key0),
    .req_hold(req_hold0), .contact(contact0), .busy(busy0), .done(done0)
  );

  keypad_matrix_emulator #(.BOUNCE_CYCLES(B1), .GAP_CYCLES(GAP), .LFSR_SEED(SEED)) dut1 (
    .clk(clk), .rst(rst), .row_sweep(row_sweep), .column_in(column_in1),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_key(req_key1),
    .req_hold(req_hold1), .contact(contact1), .busy(busy1), .done(done1)
  );

  // Expected per-press responses: contact trace, busy length and key.
  bit          exp_c0[$], exp_c1[$];
  int          exp_len0[$], exp_len1[$];
  logic [3:0]  exp_key0[$], exp_key1[$];
  logic [15:0] model_lfsr;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          force_row = 1'b0;
  logic [3:0]  forced_row = 4'hF;
  bit          in_press [2];
  int          busy_cnt [2];
  logic [3:0]  cur_key  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & 16'h002D), s[15:1]};
  endfunction

  function automatic logic [3:0] exp_col(input logic [3:0] key, input bit c, input logic [3:0] rows);
    logic [3:0] asserted_rows;
    logic [3:0] cols;
    asserted_rows = ~rows;
    cols = 4'b0000;
    if (c && asserted_rows[key[3:2]]) cols[key[1:0]] = 1'b1;
    return ~cols;
  endfunction

  task automatic push_c(input int d, input bit c);
    if (d == 0) exp_c0.push_back(c);
    else        exp_c1.push_back(c);
  endtask

  // Reference: a press is the phase list make(B) / hold(h) / break(B) / gap(G).
  task automatic push_press(input int d, input logic [3:0] key, input int hold);
    int h;
    int b;
    h = (hold == 0) ? 1 : hold;
    b = (d == 1) ? B1 : 0;
    if (d == 0) begin
      exp_key0.push_back(key);
      exp_len0.push_back(2 * b + h + GAP);
    end else begin
      exp_key1.push_back(key);
      exp_len1.push_back(2 * b + h + GAP);
    end
    for (int i = 0; i < b; i++) begin push_c(d, model_lfsr[0]); model_lfsr = lfsr_step(model_lfsr); end
    for (int i = 0; i < h; i++) push_c(d, 1'b1);
    for (int i = 0; i < b; i++) begin push_c(d, model_lfsr[0]); model_lfsr = lfsr_step(model_lfsr); end
    for (int i = 0; i < GAP; i++) push_c(d, 1'b0);
  endtask

  task automatic mon(input int d, input logic c, input logic b, input logic dn, input logic [3:0] col);
    bit ec;
    int el;
    ec = 1'b0;
    if (b) begin
      if (!in_press[d]) begin
        in_press[d] = 1'b1;
        busy_cnt[d] = 0;
        if ((d == 0 && exp_key0.size() == 0) || (d == 1 && exp_key1.size() == 0)) begin
          check($sformatf("press_unexpected%0d", d), b, 0);
          cur_key[d] = 4'h0;
        end else if (d == 0) cur_key[d] = exp_key0.pop_front();
        else                 cur_key[d] = exp_key1.pop_front();
      end
      busy_cnt[d]++;
      check($sformatf("done_while_busy%0d", d), dn, 0);
      if ((d == 0 && exp_c0.size() == 0) || (d == 1 && exp_c1.size() == 0)) begin
        check($sformatf("contact_underrun%0d", d), b, 0);
      end else begin
        ec = (d == 0) ? exp_c0.pop_front() : exp_c1.pop_front();
        check($sformatf("contact%0d", d), c, ec);
      end
    end else begin
      check($sformatf("idle_contact%0d", d), c, 0);
      if (dn) begin
        if (!in_press[d] || (d == 0 && exp_len0.size() == 0) || (d == 1 && exp_len1.size() == 0)) begin
          check($sformatf("done_unexpected%0d", d), dn, 0);
        end else begin
          el = (d == 0) ? exp_len0.pop_front() : exp_len1.pop_front();
          check($sformatf("press_length%0d", d), busy_cnt[d], el);
        end
      end else if (in_press[d]) begin
        check($sformatf("done_missing%0d", d), dn, 1);
      end
      in_press[d] = 1'b0;
    end
    check($sformatf("column%0d", d), col, exp_col(cur_key[d], ec, row_sweep));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      in_press[0] = 1'b0;
      in_press[1] = 1'b0;
    end else begin
      mon(0, contact0, busy0, done0, column_in0);
      mon(1, contact1, busy1, done1, column_in1);
    end
  end

  // Row scanner stand-in: mostly one row asserted, occasionally arbitrary patterns.
  initial begin
    logic [3:0] a;
    row_sweep = 4'hF;
    forever begin
      @(posedge clk);
      #1;
      if (force_row) row_sweep = forced_row;
      else begin
        a = 4'b0001 << $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0) a = 4'($urandom);
        row_sweep = ~a;
      end
    end
  end

  function automatic logic ready_of(input int d);
    return (d == 0) ? req_ready0 : req_ready1;
  endfunction

  task automatic drive(input int d, input logic v, input logic [3:0] k, input int h);
    if (d == 0) begin req_valid0 = v; req_key0 = k; req_hold0 = 16'(h); end
    else        begin req_valid1 = v; req_key1 = k; req_hold1 = 16'(h); end
  endtask

  task automatic wait_ready(input int d, input string name);
    int n;
    n = 0;
    while (!ready_of(d) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, ready_of(d), 1);
  endtask

  task automatic do_press(input int d, input logic [3:0] key, input int hold);
    push_press(d, key, hold);
    drive(d, 1'b1, key, hold);
    wait_ready(d, "accept_timeout");
    @(posedge clk);
    #1;
    drive(d, 1'b0, key, hold);
    @(posedge clk);
    #1;
    wait_ready(d, "complete_timeout");
  endtask

  task automatic flush_model();
    exp_c0.delete();   exp_c1.delete();
    exp_len0.delete(); exp_len1.delete();
    exp_key0.delete(); exp_key1.delete();
    model_lfsr = SEED;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 4'h0, 0);
    drive(1, 1'b0, 4'h0, 0);
    model_lfsr = SEED;
    #3;
    check("rst_col0", column_in0, 4'hF);
    check("rst_col1", column_in1, 4'hF);
    check("rst_contact0", contact0, 0);
    check("rst_contact1", contact1, 0);
    check("rst_busy0", busy0, 0);
    check("rst_done1", done1, 0);
    check("rst_ready0", req_ready0, 1);
    check("rst_ready1", req_ready1, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of HOLD aborts the press with no done.
    push_press(0, 4'h5, 200);
    force_row  = 1'b1;
    forced_row = 4'b1101;
    drive(0, 1'b1, 4'h5, 200);
    wait_ready(0, "rst_accept");
    @(posedge clk);
    #1;
    drive(0, 1'b0, 4'h5, 200);
    repeat (20) @(posedge clk);
    #1;
    check("rst_pre_col", column_in0, 4'b1101);
    #2 rst = 1'b1;
    #1;
    check("rst_async_col", column_in0, 4'hF);
    check("rst_async_contact", contact0, 0);
    check("rst_async_busy", busy0, 0);
    flush_model();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ready_after", req_ready0, 1);
    check("rst_no_done", done0, 0);

    // Basic press: key 9, hold 100, no bounce.
    push_press(0, 4'h9, 100);
    forced_row = 4'b1011;
    drive(0, 1'b1, 4'h9, 100);
    wait_ready(0, "basic_accept");
    @(posedge clk);
    #1;
    drive(0, 1'b0, 4'h9, 100);
    repeat (10) @(posedge clk);
    #3;
    check("basic_col_row2", column_in0, 4'b1101);
    forced_row = 4'b1110;
    @(posedge clk);
    #3;
    check("basic_col_row0", column_in0, 4'hF);
    forced_row = 4'b1011;
    @(posedge clk);
    #3;
    check("basic_col_row2_again", column_in0, 4'b1101);
    force_row = 1'b0;
    @(posedge clk);
    #1;
    wait_ready(0, "basic_complete");

    // Bounce from the reset seed.
    do_press(1, 4'hA, 20);

    // Held req_valid: second key taken only after done.
    push_press(0, 4'h3, 20);
    push_press(0, 4'hC, 10);
    drive(0, 1'b1, 4'h3, 20);
    wait_ready(0, "hs_accept");
    @(posedge clk);
    #1;
    drive(0, 1'b1, 4'hC, 10);
    check("hs_not_ready", req_ready0, 0);
    wait_ready(0, "hs_done");
    check("hs_done_with_ready", done0, 1);
    @(posedge clk);
    #1;
    check("hs_second_accepted", busy0, 1);
    drive(0, 1'b0, 4'hC, 10);
    wait_ready(0, "hs_complete");

    // Zero hold behaves as one cycle.
    do_press(0, 4'h6, 0);
    do_press(1, 4'h7, 0);

    fork
      begin
        for (int i = 0; i < 10; i++) do_press(0, 4'($urandom), $urandom_range(0, 40));
      end
      begin
        do_press(1, 4'h0, 30);
        do_press(1, 4'hF, 30);
        for (int i = 0; i < 8; i++) do_press(1, 4'($urandom), $urandom_range(0, 40));
      end
    join

    repeat (5) @(posedge clk);
    #1;
    check("leftover_contact0", 32'(exp_c0.size()), 0);
    check("leftover_contact1", 32'(exp_c1.size()), 0);
    check("leftover_len0", 32'(exp_len0.size()), 0);
    check("leftover_len1", 32'(exp_len1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
